cmd_issue_arbiter: RTL and testbench
====================================

// Module: cmd_issue_arbiter
// PURPOSE
//   Shares the single host cmd_controller between two command requesters (0: register/software
//   path, 1: data-transfer controller, e.g. CMD12/CMD17). Arbitrates, latches index/argument,
//   pulses new_command, runs the response timeout, then returns the response and status
//   to the granted requester. Sits directly upstream of cmd_controller in the clock domain.
// PARAMETERS
//   TIMEOUT_CYCLES  64  clock cycles from new_command pulse to timeout; must be >= 1
//   TIMER_W         16  timeout counter width; TIMEOUT_CYCLES < 2**TIMER_W
// PORTS
//   clock            in   1    system clock; all state updates on posedge
//   reset            in   1    asynchronous, active-high reset
//   req0_valid       in   1    requester 0 has a command; held until req0_ack
//   req0_index       in   6    requester 0 command index
//   req0_argument    in   32   requester 0 command argument
//   req0_ack         out  1    one-cycle pulse: req0 command accepted and latched
//   req0_done        out  1    one-cycle pulse: req0 command finished
//   req1_valid/req1_index/req1_argument/req1_ack/req1_done  same as requester 0
//   done_timeout     out  1    valid with reqN_done: 1 = timed out, 0 = response received
//   resp_data        out  136  last latched response; stable from reqN_done until next done
//   timeout_enable   in   1    1 = timer active; 0 = wait for cmd_done indefinitely
//   new_command      out  1    one-cycle pulse to cmd_controller
//   cmd_index        out  6    to cmd_controller; stable ISSUE..DONE
//   cmd_argument     out  32   to cmd_controller; stable ISSUE..DONE
//   cmd_done         in   1    pulse from cmd_controller: response available
//   cmd_response     in   136  response frame, valid when cmd_done=1
//   cmd_timeout      out  1    one-cycle pulse to cmd_controller TIMEOUT on expiry
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (resp_data, cmd_index, cmd_argument all zero); timer 0;
//     last_grant=1 so requester 0 wins the first tie. Reset mid-command aborts silently: no done.
//   FSM (all outputs registered):
//     IDLE  : sample valids; none -> stay. Else choose grant, latch index/argument into
//             cmd_index/cmd_argument, pulse reqN_ack next cycle, -> ISSUE.
//     ISSUE : new_command=1 for exactly this cycle; timer <= TIMEOUT_CYCLES; -> WAIT.
//     WAIT  : timer decrements each cycle when timeout_enable=1 (holds when 0).
//             cmd_done=1 -> resp_data <= cmd_response, status ok, -> DONE.
//             timer==1 and decrementing and no cmd_done -> cmd_timeout pulse, status timeout, -> DONE.
//             cmd_done and expiry same cycle -> cmd_done wins, no cmd_timeout.
//     DONE  : pulse reqN_done (granted N only) with done_timeout; last_grant <= N; -> IDLE.
//   Latency: valid sampled in IDLE at edge k -> ack high k+1, new_command high k+2;
//     cmd_done at edge m -> reqN_done high m+1. Min gap between new_command pulses: 4 cycles.
//   Arbitration: both valid -> grant the requester != last_grant (round robin).
//   cmd_done outside WAIT is ignored. Valid dropped before ack -> not granted, no error.
//   On timeout resp_data keeps previous value.
//   Requester must not change index/argument while valid=1 and before ack.
// CONFIGURATION
//   CMD_ARB_FIXED_PRIORITY_EN defined: requester 0 always wins ties; last_grant unused.
//   Not defined: round-robin as above.
// TESTING
//   1 req0 only, idx=17 arg=32'h0000_0200, cmd_done at +5 with resp 136'h..3BA692AF ->
//     ack k+1, new_command k+2, cmd_index=17, req0_done, done_timeout=0, resp_data matches.
//   2 req0,req1 valid together from reset -> req0 granted first, req1 next, new_command pulses 4+ cycles apart.
//   3 no cmd_done, timeout_enable=1, TIMEOUT_CYCLES=64 -> cmd_timeout pulse 64 cycles after
//     new_command, req done with done_timeout=1, resp_data unchanged.
//   4 timeout_enable=0, cmd_done after 200 cycles -> no timeout, done_timeout=0.
//   5 cmd_done on expiry cycle -> done_timeout=0, cmd_timeout stays 0.
//   6 reset asserted in WAIT -> outputs 0, IDLE, no done; pending req0 re-granted after release;
//     rerun test 2 with CMD_ARB_FIXED_PRIORITY_EN -> req0 wins every tie.

Source files
------------

// File: rtl/cmd_issue_arbiter.sv
// Two-requester front end for the host cmd_controller: arbitrate, issue, time out, return response.
// Define CMD_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of round robin.
module cmd_issue_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMER_W        = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [5:0]   req0_index,
  input  logic [31:0]  req0_argument,
  output logic         req0_ack,
  output logic         req0_done,
  input  logic         req1_valid,
  input  logic [5:0]   req1_index,
  input  logic [31:0]  req1_argument,
  output logic         req1_ack,
  output logic         req1_done,
  output logic         done_timeout,
  output logic [135:0] resp_data,
  input  logic         timeout_enable,
  output logic         new_command,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_argument,
  input  logic         cmd_done,
  input  logic [135:0] cmd_response,
  output logic         cmd_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] argument;
  } cmd_t;

  state_t             state, state_nxt;
  cmd_t   [1:0]       req;
  logic   [1:0]       req_valid, ack, done;
  logic   [TIMER_W-1:0] timer;
  logic               grant, grant_nxt;
  logic               tick, expire;

  assign req_valid = {req1_valid, req0_valid};
  assign req[0]    = {req0_index, req0_argument};
  assign req[1]    = {req1_index, req1_argument};
  assign {req1_ack, req0_ack}   = ack;
  assign {req1_done, req0_done} = done;

  assign tick   = (state == WAIT) && timeout_enable;
  assign expire = tick && (timer == TIMER_W'(1));

`ifdef CMD_ARB_FIXED_PRIORITY_EN
  assign grant_nxt = ~req_valid[0];
`else
  logic last_grant;
  // On a tie, hand the grant to whoever was not served last.
  assign grant_nxt = (&req_valid) ? ~last_grant : ~req_valid[0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cmd_done || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack          <= '0;
      done         <= '0;
      done_timeout <= 1'b0;
      new_command  <= 1'b0;
      cmd_timeout  <= 1'b0;
      cmd_index    <= '0;
      cmd_argument <= '0;
      resp_data    <= '0;
      timer        <= '0;
      grant        <= 1'b0;
`ifndef CMD_ARB_FIXED_PRIORITY_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      ack          <= '0;
      done         <= '0;
      done_timeout <= 1'b0;
      new_command  <= 1'b0;
      cmd_timeout  <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          grant                     <= grant_nxt;
          {cmd_index, cmd_argument} <= req[grant_nxt];
          ack[grant_nxt]            <= 1'b1;
        end
        ISSUE: begin
          new_command <= 1'b1;
          timer       <= TIMER_W'(TIMEOUT_CYCLES);
        end
        WAIT: begin
          if (tick) timer <= timer - 1'b1;
          // A response landing on the expiry cycle still counts as a response.
          if (cmd_done) begin
            resp_data   <= cmd_response;
            done[grant] <= 1'b1;
          end else if (expire) begin
            cmd_timeout  <= 1'b1;
            done_timeout <= 1'b1;
            done[grant]  <= 1'b1;
          end
        end
        DONE: begin
`ifndef CMD_ARB_FIXED_PRIORITY_EN
          last_grant <= grant;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_issue_arbiter.sv
// Self-checking bench for cmd_issue_arbiter: directed scenarios plus randomized traffic vs. a timestamp model.
module tb_cmd_issue_arbiter;
  localparam int TO = 64;
  localparam int S_ACK0 = 0, S_ACK1 = 1, S_NC = 2, S_DONE0 = 3, S_DONE1 = 4,
                 S_TO = 5, S_ACKANY = 6, S_DONEANY = 7;
  localparam logic [135:0] R1 = 136'h3F_1234_5678_9ABC_DEF0_0000_0000_3BA6_92AF;
  localparam logic [135:0] R2 = 136'h01_AAAA_5555_0000_FFFF_1111_2222_3333_4444;
  localparam logic [135:0] R4 = 136'h80_0F0F_F0F0_1357_2468_DEAD_BEEF_0000_0042;
  localparam logic [135:0] R5 = 136'h7E_CAFE_F00D_8765_4321_0BAD_C0DE_1234_5678;

  logic         clock = 1'b0, reset = 1'b1;
  logic         req0_valid, req1_valid, req0_ack, req1_ack, req0_done, req1_done;
  logic [5:0]   req0_index, req1_index, cmd_index;
  logic [31:0]  req0_argument, req1_argument, cmd_argument;
  logic         done_timeout, timeout_enable, new_command, cmd_done, cmd_timeout;
  logic [135:0] resp_data, cmd_response;

  cmd_issue_arbiter #(.TIMEOUT_CYCLES(TO), .TIMER_W(16)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_index(req0_index), .req0_argument(req0_argument),
    .req0_ack(req0_ack), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_index(req1_index), .req1_argument(req1_argument),
    .req1_ack(req1_ack), .req1_done(req1_done),
    .done_timeout(done_timeout), .resp_data(resp_data), .timeout_enable(timeout_enable),
    .new_command(new_command), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
    .cmd_done(cmd_done), .cmd_response(cmd_response), .cmd_timeout(cmd_timeout)
  );

  initial forever #5 clock = ~clock;

  int checks = 0, passes = 0, fails = 0;
  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [135:0] rnd136();
    return {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
  endfunction

  // Reference model: a command is a grant timestamp t_g; ack at t_g, new_command at t_g+1,
  // completion at the first response (or the TO-th enabled waiting edge), re-arbitration two edges later.
  int cyc = 0, t_g = 0, en_cnt = 0, next_free = 0, g = 0, last = 1;
  bit active = 0;
  logic e_ack0, e_ack1, e_nc, e_d0, e_d1, e_to, e_dto;
  logic [5:0] e_idx;
  logic [31:0] e_arg;
  logic [135:0] e_resp;

  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      active = 0; last = 1; next_free = 0;
      {e_ack0, e_ack1, e_nc, e_d0, e_d1, e_to, e_dto} = '0;
      e_idx = '0; e_arg = '0; e_resp = '0;
    end else begin
      {e_ack0, e_ack1, e_nc, e_d0, e_d1, e_to, e_dto} = '0;
      if (!active) begin
        if (cyc >= next_free && (req0_valid || req1_valid)) begin
`ifdef CMD_ARB_FIXED_PRIORITY_EN
          g = req0_valid ? 0 : 1;
`else
          if (req0_valid && req1_valid) g = (last == 0) ? 1 : 0;
          else g = req0_valid ? 0 : 1;
`endif
          active = 1; t_g = cyc; en_cnt = 0;
          e_idx = g ? req1_index : req0_index;
          e_arg = g ? req1_argument : req0_argument;
          if (g) e_ack1 = 1; else e_ack0 = 1;
        end
      end else if (cyc == t_g + 1) begin
        e_nc = 1;
      end else begin
        if (timeout_enable) en_cnt++;
        if (cmd_done || (timeout_enable && en_cnt == TO)) begin
          if (cmd_done) e_resp = cmd_response;
          else begin e_to = 1; e_dto = 1; end
          if (g) e_d1 = 1; else e_d0 = 1;
          active = 0; last = g; next_free = cyc + 2;
        end
      end
    end
  end

  int nc_stamp[$];
  initial forever begin
    @(negedge clock);
    chk("req0_ack", req0_ack, e_ack0);
    chk("req1_ack", req1_ack, e_ack1);
    chk("new_command", new_command, e_nc);
    chk("req0_done", req0_done, e_d0);
    chk("req1_done", req1_done, e_d1);
    chk("cmd_timeout", cmd_timeout, e_to);
    chk("done_timeout", done_timeout, e_dto);
    chk("cmd_index", cmd_index, e_idx);
    chk("cmd_argument", cmd_argument, e_arg);
    chk("resp_data", resp_data, e_resp);
    if (new_command) nc_stamp.push_back(cyc);
  end

  // cmd_controller stand-in: answers resp_delay ticks after new_command (-1 = never).
  int resp_delay = -1;
  bit rand_mode = 0;
  logic [135:0] resp_pat = '0;
  initial begin
    int pend;
    pend = -1; cmd_done = 0; cmd_response = '0;
    forever begin
      @(negedge clock); #1;
      cmd_done = 0;
      if (new_command) pend = rand_mode ? (($urandom % 5 == 0) ? -1 : int'($urandom_range(0, 70)))
                                        : resp_delay;
      if (pend == 0) begin
        cmd_done = 1; cmd_response = rand_mode ? rnd136() : resp_pat; pend = -1;
      end else if (pend > 0) pend--;
      else if (rand_mode && ($urandom % 40 == 0)) begin
        cmd_done = 1; cmd_response = rnd136();
      end
    end
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  function automatic bit sig(int s);
    case (s)
      S_ACK0:    return req0_ack;
      S_ACK1:    return req1_ack;
      S_NC:      return new_command;
      S_DONE0:   return req0_done;
      S_DONE1:   return req1_done;
      S_TO:      return cmd_timeout;
      S_ACKANY:  return req0_ack | req1_ack;
      default:   return req0_done | req1_done;
    endcase
  endfunction

  task automatic wait_sig(input int s, input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (!sig(s) && n < bound);
    chk($sformatf("wait_sig_%0d", s), sig(s), 1'b1);
  endtask

  initial begin
    int n, s0, to_seen;
    req0_valid = 0; req1_valid = 0; req0_index = '0; req1_index = '0;
    req0_argument = '0; req1_argument = '0; timeout_enable = 1;
    repeat (3) tick();
    chk("rst_new_command", new_command, 1'b0);
    chk("rst_cmd_index", cmd_index, 6'd0);
    chk("rst_resp_data", resp_data, 136'd0);
    reset = 0; tick();

    // 1: single req0 command with a response
    resp_pat = R1; resp_delay = 4;
    req0_valid = 1; req0_index = 6'd17; req0_argument = 32'h0000_0200;
    wait_sig(S_ACK0, 10, n); chk("t1_ack_latency", n, 1); req0_valid = 0;
    wait_sig(S_NC, 10, n);   chk("t1_nc_latency", n, 1);
    chk("t1_cmd_index", cmd_index, 6'd17);
    chk("t1_cmd_argument", cmd_argument, 32'h0000_0200);
    wait_sig(S_DONE0, 20, n); chk("t1_done_latency", n, 5);
    chk("t1_done_timeout", done_timeout, 1'b0);
    chk("t1_resp_data", resp_data, R1);

    // 2: simultaneous requests from reset
    reset = 1; repeat (2) tick(); reset = 0;
    resp_pat = R2; resp_delay = 0; s0 = nc_stamp.size();
    req0_index = 6'd1; req0_argument = 32'h11; req1_index = 6'd2; req1_argument = 32'h22;
    req0_valid = 1; req1_valid = 1;
    wait_sig(S_ACKANY, 10, n);
    chk("t2_first_req0", req0_ack, 1'b1); chk("t2_first_not_req1", req1_ack, 1'b0);
    req0_index = 6'd3; req0_argument = 32'h33;
    wait_sig(S_ACKANY, 20, n);
`ifdef CMD_ARB_FIXED_PRIORITY_EN
    chk("t2_second_req0", req0_ack, 1'b1); req0_valid = 0;
`else
    chk("t2_second_req1", req1_ack, 1'b1); req1_valid = 0;
`endif
    wait_sig(S_ACKANY, 20, n);
`ifdef CMD_ARB_FIXED_PRIORITY_EN
    chk("t2_third_req1", req1_ack, 1'b1); req1_valid = 0;
`else
    chk("t2_third_req0", req0_ack, 1'b1); req0_valid = 0;
`endif
    wait_sig(S_NC, 10, n);
    wait_sig(S_DONEANY, 20, n);
    chk("t2_nc_count", nc_stamp.size() - s0, 3);
    for (int i = s0 + 1; i < nc_stamp.size(); i++)
      chk("t2_nc_gap_ge4", (nc_stamp[i] - nc_stamp[i-1]) >= 4, 1'b1);

    // 3: timeout with no response
    resp_delay = -1; timeout_enable = 1;
    req0_valid = 1; req0_index = 6'd5;
    wait_sig(S_ACK0, 10, n); req0_valid = 0;
    wait_sig(S_NC, 10, n);
    wait_sig(S_TO, 80, n); chk("t3_timeout_latency", n, TO);
    chk("t3_req0_done", req0_done, 1'b1);
    chk("t3_done_timeout", done_timeout, 1'b1);
    chk("t3_resp_kept", resp_data, R2);

    // 4: timer disabled, late response
    timeout_enable = 0; resp_delay = 200; resp_pat = R4;
    req1_valid = 1; req1_index = 6'd12; req1_argument = 32'hABCD_0001;
    wait_sig(S_ACK1, 10, n); req1_valid = 0;
    wait_sig(S_NC, 10, n);
    n = 0; to_seen = 0;
    do begin tick(); n++; if (cmd_timeout) to_seen++; end while (!req1_done && n < 260);
    chk("t4_done_latency", n, 201);
    chk("t4_no_timeout", to_seen, 0);
    chk("t4_done_timeout", done_timeout, 1'b0);
    chk("t4_resp_data", resp_data, R4);

    // 5: response on the expiry cycle
    timeout_enable = 1; resp_delay = TO - 1; resp_pat = R5;
    req0_valid = 1; req0_index = 6'd7;
    wait_sig(S_ACK0, 10, n); req0_valid = 0;
    wait_sig(S_NC, 10, n);
    wait_sig(S_DONE0, 80, n); chk("t5_done_latency", n, TO);
    chk("t5_cmd_timeout", cmd_timeout, 1'b0);
    chk("t5_done_timeout", done_timeout, 1'b0);
    chk("t5_resp_data", resp_data, R5);

    // 6: reset while waiting; still-pending req0 is granted right after release
    resp_delay = -1;
    req0_valid = 1; req0_index = 6'd9;
    wait_sig(S_ACK0, 10, n);
    wait_sig(S_NC, 10, n);
    repeat (3) tick();
    reset = 1; tick();
    chk("t6_rst_done", req0_done, 1'b0);
    chk("t6_rst_cmd_index", cmd_index, 6'd0);
    chk("t6_rst_resp", resp_data, 136'd0);
    tick(); resp_delay = 1; reset = 0;
    wait_sig(S_ACK0, 10, n); chk("t6_regrant_latency", n, 1); req0_valid = 0;
    wait_sig(S_DONE0, 20, n);
    chk("t6_done_timeout", done_timeout, 1'b0);

    // Randomized traffic
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (reset) reset = 0;
      else if ($urandom % 600 == 0) reset = 1;
      if ($urandom % 25 == 0) timeout_enable = ~timeout_enable;
      if (req0_ack) begin
        req0_valid = $urandom % 2;
        req0_index = 6'($urandom); req0_argument = $urandom;
      end else if (!req0_valid) begin
        if ($urandom % 4 == 0) begin
          req0_valid = 1; req0_index = 6'($urandom); req0_argument = $urandom;
        end
      end else if ($urandom % 60 == 0) req0_valid = 0;
      if (req1_ack) begin
        req1_valid = $urandom % 2;
        req1_index = 6'($urandom); req1_argument = $urandom;
      end else if (!req1_valid) begin
        if ($urandom % 4 == 0) begin
          req1_valid = 1; req1_index = 6'($urandom); req1_argument = $urandom;
        end
      end else if ($urandom % 60 == 0) req1_valid = 0;
    end
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
